// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable tick generators with periodic/one-shot modes,
// square-wave outputs and deferred (terminal-count aligned) divisor reload.
module multi_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic              cfg_sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] pend
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] count_q;
        logic [WIDTH-1:0] pend_div_q;
        logic             mode_q;
        logic             pend_mode_q;
        logic             pend_q;
        logic             tick_q;
        logic             sq_q;
        logic             done_q;
        state_e           state_q;

        logic [WIDTH-1:0] n_eff_s;
        logic             wr_hit_s;
        logic             wr_now_s;
        logic             wr_defer_s;
        logic             terminal_s;

        // A divisor of zero counts as one so the terminal compare never underflows.
        assign n_eff_s    = (div_q == {WIDTH{1'b0}}) ? WIDTH'(1) : div_q;
        assign wr_hit_s   = cfg_wr && (cfg_ch == CH_W'(gi));
        assign wr_now_s   = wr_hit_s && (!cfg_sync || (state_q == ST_IDLE));
        assign wr_defer_s = wr_hit_s && cfg_sync && (state_q == ST_RUN);
        assign terminal_s = (state_q == ST_RUN) && en[gi] &&
                            (count_q == (n_eff_s - WIDTH'(1)));

        // Channel state machine: counting, tick/square generation and reload handling.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q       <= WIDTH'(DEFAULT_DIV);
                count_q     <= {WIDTH{1'b0}};
                pend_div_q  <= {WIDTH{1'b0}};
                mode_q      <= 1'b0;
                pend_mode_q <= 1'b0;
                pend_q      <= 1'b0;
                tick_q      <= 1'b0;
                sq_q        <= 1'b0;
                done_q      <= 1'b0;
                state_q     <= ST_RUN;
            end else begin
                tick_q <= 1'b0;
                if (wr_now_s) begin
                    // An immediate write wins over a coincident terminal count.
                    div_q   <= cfg_div;
                    mode_q  <= cfg_mode;
                    count_q <= {WIDTH{1'b0}};
                    state_q <= ST_RUN;
                    done_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (terminal_s) begin
                                count_q <= {WIDTH{1'b0}};
                                tick_q  <= 1'b1;
                                sq_q    <= ~sq_q;
                                if (pend_q) begin
                                    div_q  <= pend_div_q;
                                    mode_q <= pend_mode_q;
                                    pend_q <= 1'b0;
                                    done_q <= 1'b0;
                                end else if (mode_q) begin
                                    state_q <= ST_IDLE;
                                    done_q  <= 1'b1;
                                end else begin
                                    done_q <= done_q;
                                end
                            end else if (en[gi]) begin
                                count_q <= count_q + WIDTH'(1);
                            end else begin
                                count_q <= count_q;
                            end
                        end
                        ST_IDLE: begin
                            count_q <= {WIDTH{1'b0}};
                        end
                        default: begin
                            state_q <= ST_RUN;
                        end
                    endcase
                    // Placed after the terminal load so a coincident deferred write stays pending.
                    if (wr_defer_s) begin
                        pend_div_q  <= cfg_div;
                        pend_mode_q <= cfg_mode;
                        pend_q      <= 1'b1;
                    end else begin
                        pend_div_q  <= pend_div_q;
                    end
                end
            end
        end

        assign tick[gi] = tick_q;
        assign sq[gi]   = sq_q;
        assign done[gi] = done_q;
        assign pend[gi] = pend_q;
    end

endmodule
